// File: rtl/state_compress_pkg.sv
// Shared Kyber parameters for the ciphertext compression block.
// Holds the modulus, compression widths, BRAM/ciphertext word widths, the
// address map of the Add BRAM regions, the FSM state type and the
// reciprocal constant used to replace the divide by KYBER_Q.
package state_compress_pkg;

    localparam int unsigned KYBER_Q       = 3329;
    localparam int unsigned KYBER_DU      = 10;
    localparam int unsigned KYBER_DV      = 4;
    localparam int unsigned ADD_BRAM_W    = 128;
    localparam int unsigned CT_W          = 80;
    localparam int unsigned ADDR_W        = 7;
    localparam int unsigned COEF_W        = 12;
    localparam int unsigned COEF_SLOT_W   = 16;
    localparam int unsigned COEF_PER_WORD = 8;

    // Add BRAM region base addresses: EncBp0, EncBp1, EncV, end of map.
    localparam int unsigned BASE_BP0 = 0;
    localparam int unsigned BASE_BP1 = 32;
    localparam int unsigned BASE_V   = 64;
    localparam int unsigned BASE_END = 96;

    // floor(n / q) == (n * ceil(2^36 / q)) >> 36 whenever n * err < 2^36, where
    // err = ceil(2^36/q)*q - 2^36 < q. For q = 3329, d <= 11 and x <= 4095 the
    // numerator stays below 2^24, so the product error never reaches one ulp.
    localparam int unsigned DIV_SHIFT = 36;

    function automatic logic [63:0] div_mult(input int unsigned q);
        return ((64'd1 << DIV_SHIFT) + 64'(q) - 64'd1) / 64'(q);
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StRdBp,
        StRdV,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/state_compress_if.sv
// Bus bundle between the compressor, the Add BRAM and the ciphertext store.
//   enable                 start request
//   Add_EncBp_DecMp_RData  Add BRAM read data (1-cycle latency)
//   Add_EncBp_DecMp_RAd    Add BRAM read address
//   ct_outready            ciphertext write strobe
//   ct_WAd / ct_WData      ciphertext write address / data
//   Function_done          one-cycle completion pulse
// slave: the compressor; master: the environment driving it.
interface state_compress_if;
    import state_compress_pkg::*;

    logic                  enable;
    logic [ADD_BRAM_W-1:0] Add_EncBp_DecMp_RData;
    logic [ADDR_W-1:0]     Add_EncBp_DecMp_RAd;
    logic                  ct_outready;
    logic [ADDR_W-1:0]     ct_WAd;
    logic [CT_W-1:0]       ct_WData;
    logic                  Function_done;

    modport master (
        output enable,
        output Add_EncBp_DecMp_RData,
        input  Add_EncBp_DecMp_RAd,
        input  ct_outready,
        input  ct_WAd,
        input  ct_WData,
        input  Function_done
    );

    modport slave (
        input  enable,
        input  Add_EncBp_DecMp_RData,
        output Add_EncBp_DecMp_RAd,
        output ct_outready,
        output ct_WAd,
        output ct_WData,
        output Function_done
    );

endinterface

// File: rtl/state_compress_comp.sv
// Single-coefficient compressor: y = floor((x*2^d + floor(q/2)) / q) mod 2^d.
// Purely combinational; the divide is a constant multiply followed by a shift.
//   x_i  12-bit coefficient (any value 0..4095)
//   y_o  d-bit compressed value
module state_compress_comp
    import state_compress_pkg::*;
#(
    parameter int unsigned d = KYBER_DU,
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [COEF_W-1:0] x_i,
    output logic [d-1:0]      y_o
);

    localparam logic [63:0] Mult = div_mult(Q);
    localparam logic [63:0] Half = 64'(Q / 2);

    logic [63:0] num;
    logic [63:0] prod;

    always_comb begin
        num  = (64'(x_i) << d) + Half;
        prod = num * Mult;
        // Truncation to d bits is the final mod 2^d.
        y_o  = d'(prod >> DIV_SHIFT);
    end

endmodule

// File: rtl/state_compress.sv
// Streams the 96 Add BRAM words through the Kyber compressor and writes one
// ciphertext word per cycle. Words 0-63 (bp) use KYBER_DU bits per
// coefficient, words 64-95 (v) use KYBER_DV bits with the upper bits zeroed.
// Pipeline: address issued in cycle n, data back in n+1, write visible in n+2.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  state_compress_if slave: enable, BRAM read port, ciphertext write port,
//        Function_done
module state_compress #(
    parameter int unsigned KYBER_Q           = state_compress_pkg::KYBER_Q,
    parameter int unsigned KYBER_DU          = state_compress_pkg::KYBER_DU,
    parameter int unsigned KYBER_DV          = state_compress_pkg::KYBER_DV,
    parameter int unsigned i_Add_BRAM_Length = state_compress_pkg::ADD_BRAM_W,
    parameter int unsigned o_ct_Length       = state_compress_pkg::CT_W
) (
    input  logic             clk,
    input  logic             rst,
    state_compress_if.slave  bus
);
    import state_compress_pkg::*;

    localparam logic [ADDR_W-1:0] AddrFirst = ADDR_W'(BASE_BP0);
    localparam logic [ADDR_W-1:0] AddrV     = ADDR_W'(BASE_V);
    localparam logic [ADDR_W-1:0] LastBp    = ADDR_W'(BASE_V - 1);
    localparam logic [ADDR_W-1:0] LastWord  = ADDR_W'(BASE_END - 1);

    state_e                   state_q;
    logic [ADDR_W-1:0]        cnt_q;      // next address to issue
    logic [ADDR_W-1:0]        rad_q;
    logic                     iss_vld_q;  // rad_q carries a real read this cycle
    logic                     dat_vld_q;  // RData holds the word at dat_addr_q
    logic [ADDR_W-1:0]        dat_addr_q;
    logic                     wr_q;
    logic [ADDR_W-1:0]        wad_q;
    logic [o_ct_Length-1:0]   wdata_q;
    logic [o_ct_Length-1:0]   wdata_d;
    logic                     done_q;

    logic [i_Add_BRAM_Length-1:0]  rdata;
    logic [KYBER_DU-1:0]           bp_c [COEF_PER_WORD];
    logic [KYBER_DV-1:0]           v_c  [COEF_PER_WORD];
    logic [4*COEF_PER_WORD-1:0]    unused_hi_bits;

    assign rdata = bus.Add_EncBp_DecMp_RData;

    for (genvar j = 0; j < COEF_PER_WORD; j++) begin : g_comp
        state_compress_comp #(
            .d (KYBER_DU),
            .Q (KYBER_Q)
        ) u_bp (
            .x_i (rdata[COEF_SLOT_W*j +: COEF_W]),
            .y_o (bp_c[j])
        );

        state_compress_comp #(
            .d (KYBER_DV),
            .Q (KYBER_Q)
        ) u_v (
            .x_i (rdata[COEF_SLOT_W*j +: COEF_W]),
            .y_o (v_c[j])
        );

        // Top nibble of each 16-bit slot carries no coefficient data.
        assign unused_hi_bits[4*j +: 4] = rdata[COEF_SLOT_W*j+COEF_W +: 4];
    end

    always_comb begin
        wdata_d = '0;
        if (dat_addr_q >= AddrV) begin
            for (int j = 0; j < COEF_PER_WORD; j++) begin
                wdata_d[KYBER_DV*j +: KYBER_DV] = v_c[j];
            end
        end else begin
            for (int j = 0; j < COEF_PER_WORD; j++) begin
                wdata_d[KYBER_DU*j +: KYBER_DU] = bp_c[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= AddrFirst;
            rad_q      <= '0;
            iss_vld_q  <= 1'b0;
            dat_vld_q  <= 1'b0;
            dat_addr_q <= '0;
            wr_q       <= 1'b0;
            wad_q      <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            rad_q      <= '0;
            iss_vld_q  <= 1'b0;
            dat_vld_q  <= iss_vld_q;
            dat_addr_q <= rad_q;
            wr_q       <= dat_vld_q;
            done_q     <= 1'b0;
            if (dat_vld_q) begin
                wad_q   <= dat_addr_q;
                wdata_q <= wdata_d;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.enable) begin
                        state_q <= StRdBp;
                        cnt_q   <= AddrFirst;
                    end
                end
                StRdBp: begin
                    rad_q     <= cnt_q;
                    iss_vld_q <= 1'b1;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == LastBp) begin
                        state_q <= StRdV;
                    end
                end
                StRdV: begin
                    rad_q     <= cnt_q;
                    iss_vld_q <= 1'b1;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave once the final write has become visible.
                    if (wr_q && (wad_q == LastWord)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.Add_EncBp_DecMp_RAd = rad_q;
    assign bus.ct_outready         = wr_q;
    assign bus.ct_WAd              = wad_q;
    assign bus.ct_WData            = wdata_q;
    assign bus.Function_done       = done_q;

endmodule

// File: tb/tb_state_compress.sv
module tb_state_compress;
    import state_compress_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    state_compress_if bus ();

    state_compress dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Add BRAM model with one cycle of read latency.
    logic [127:0] mem [96];
    always @(posedge clk) begin
        if (bus.Add_EncBp_DecMp_RAd < 7'd96)
            bus.Add_EncBp_DecMp_RData <= mem[bus.Add_EncBp_DecMp_RAd];
        else
            bus.Add_EncBp_DecMp_RData <= '0;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          n_wr;
    logic [79:0] exp_last = '0;
    logic [79:0] cap [96];

    int unsigned bp_in  [8] = '{0, 1, 1665, 3328, 832, 2496, 1664, 3000};
    int unsigned bp_out [8] = '{0, 0, 512, 0, 256, 768, 512, 923};
    int unsigned v_in   [8] = '{0, 832, 1664, 3328, 1, 2496, 208, 3120};
    int unsigned v_out  [8] = '{0, 4, 8, 0, 0, 12, 1, 15};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference compression straight from the arithmetic definition.
    function automatic int unsigned ref_c(input int unsigned x, input int unsigned d);
        return (((x << d) + KYBER_Q / 2) / KYBER_Q) % (32'd1 << d);
    endfunction

    function automatic logic [79:0] exp_word(input int a);
        logic [79:0]  w;
        int unsigned  d;
        int unsigned  x;
        w = '0;
        d = (a < 64) ? 10 : 4;
        for (int j = 0; j < 8; j++) begin
            x = 32'(mem[a][16*j +: 12]);
            w = w | (80'(ref_c(x, d)) << (d * j));
        end
        return w;
    endfunction

    function automatic logic [79:0] pack_lit(input int unsigned v [8], input int unsigned d);
        logic [79:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w = w | (80'(v[j]) << (d * j));
        return w;
    endfunction

    task automatic fill(input bit zero, input bit canonical);
        logic [11:0] x;
        for (int a = 0; a < 96; a++) begin
            for (int j = 0; j < 8; j++) begin
                x = canonical ? 12'($urandom_range(KYBER_Q - 1)) : 12'($urandom);
                mem[a][16*j +: 16] = zero ? 16'h0 : {4'($urandom), x};
            end
        end
    endtask

    task automatic set_word(input int a, input int unsigned v [8]);
        for (int j = 0; j < 8; j++) mem[a][16*j +: 16] = {4'hf, 12'(v[j])};
    endtask

    // Idle a few cycles, then raise enable so the next edge is cycle-0 edge.
    task automatic start_run();
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
    endtask

    // Checks every cycle n = 0..ncyc-1 of a run against the timing rules.
    // en_hold: edges (from edge 0) that see enable high; start2: cycle index
    // where a second run's count restarts; rst_cyc: cycle holding rst high.
    task automatic watch(input int ncyc, input int en_hold, input int start2,
                         input int rst_cyc);
        int rel;
        bit in_rst;
        n_wr = 0;
        for (int n = 0; n < ncyc; n++) begin
            in_rst = (rst_cyc >= 0) && (n > rst_cyc);
            rel    = (start2 >= 0 && n >= start2) ? n - start2 : n;
            if (in_rst) begin
                exp_last = '0;
                chk($sformatf("rst_ready@%0d", n), 128'(bus.ct_outready), 128'(0));
                chk($sformatf("rst_done@%0d", n), 128'(bus.Function_done), 128'(0));
                chk($sformatf("rst_rad@%0d", n), 128'(bus.Add_EncBp_DecMp_RAd), 128'(0));
                chk($sformatf("rst_wad@%0d", n), 128'(bus.ct_WAd), 128'(0));
                chk($sformatf("rst_wdata@%0d", n), 128'(bus.ct_WData), 128'(0));
            end else begin
                chk($sformatf("ready@%0d", n), 128'(bus.ct_outready),
                    128'(rel >= 3 && rel <= 98));
                chk($sformatf("done@%0d", n), 128'(bus.Function_done), 128'(rel == 99));
                if (rel >= 1 && rel <= 96)
                    chk($sformatf("rad@%0d", n), 128'(bus.Add_EncBp_DecMp_RAd),
                        128'(rel - 1));
                else if (rel >= 100)
                    chk($sformatf("rad_idle@%0d", n), 128'(bus.Add_EncBp_DecMp_RAd),
                        128'(0));
                if (rel >= 3 && rel <= 98) begin
                    exp_last = exp_word(rel - 3);
                    chk($sformatf("wad@%0d", n), 128'(bus.ct_WAd), 128'(rel - 3));
                end
                chk($sformatf("wdata@%0d", n), 128'(bus.ct_WData), 128'(exp_last));
            end
            if (bus.ct_outready === 1'b1) begin
                n_wr++;
                if (bus.ct_WAd < 7'd96) cap[bus.ct_WAd] = bus.ct_WData;
            end
            bus.enable = (n + 1 < en_hold);
            rst        = (rst_cyc >= 0) && (n == rst_cyc);
            @(negedge clk);
        end
        bus.enable = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0;
        fill(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(bus.ct_outready), 128'(0));
        chk("reset_done", 128'(bus.Function_done), 128'(0));
        chk("reset_rad", 128'(bus.Add_EncBp_DecMp_RAd), 128'(0));
        chk("reset_wad", 128'(bus.ct_WAd), 128'(0));
        chk("reset_wdata", 128'(bus.ct_WData), 128'(0));
        rst = 1'b0;

        // All-zero BRAM.
        start_run();
        watch(102, 1, -1, -1);
        chk("zero_nwrites", 128'(n_wr), 128'(96));

        // Boundary coefficients in word 0 (bp) and word 64 (v).
        fill(1'b0, 1'b1);
        set_word(0, bp_in);
        set_word(64, v_in);
        start_run();
        watch(102, 1, -1, -1);
        chk("bp_word0", 128'(cap[0]), 128'(pack_lit(bp_out, 10)));
        chk("v_word64", 128'(cap[64]), 128'(pack_lit(v_out, 4)));
        chk("v_word64_hi", 128'(cap[64][79:32]), 128'(0));
        chk("bnd_nwrites", 128'(n_wr), 128'(96));

        // Reset during cycle 40: writes for cycles 3..40 only, then silence.
        fill(1'b0, 1'b1);
        start_run();
        watch(130, 1, -1, 40);
        chk("rst_nwrites", 128'(n_wr), 128'(38));

        // Enable held for 200 cycles: second run starts at edge 101.
        fill(1'b0, 1'b1);
        start_run();
        watch(201, 200, 101, -1);
        chk("hold_nwrites", 128'(n_wr), 128'(192));

        // Random canonical runs, then one run over the full 12-bit range.
        for (int r = 0; r < 11; r++) begin
            fill(1'b0, r < 10);
            start_run();
            watch(102, 1, -1, -1);
            chk($sformatf("rand%0d_nwrites", r), 128'(n_wr), 128'(96));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/state_compress.md
STATE_COMPRESS -- requirements
Module: State_Compress

Interface
REQ-001 SHALL have parameters: KYBER_Q, default 3329, modulus; KYBER_DU, default 10, bp compression bits; KYBER_DV, default 4, v compression bits; i_Add_BRAM_Length, default 128, Add BRAM word width; o_ct_Length, default 80, ciphertext word width.
REQ-002 SHALL have ports, with one clock and a synchronous, active-high reset:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  start request; sampled only in IDLE.
- Add_EncBp_DecMp_RData  in  128  Add BRAM read data; 1-cycle read latency.
- Add_EncBp_DecMp_RAd  out  7  Add BRAM read address: 0-31 EncBp0, 32-63 EncBp1, 64-95 EncV.
- ct_outready  out  1  ciphertext write strobe.
- ct_WAd  out  7  ciphertext word address, 0-95.
- ct_WData  out  80  compressed word.
- Function_done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL treat each Add word as 8 coefficients; coefficient j sits at bits [16j+11:16j], with bits [16j+15:16j+12] ignored.
REQ-004 SHALL compute compress_d(x) = floor((x*2^d + floor(KYBER_Q/2)) / KYBER_Q) mod 2^d exactly, for every 12-bit x including x >= KYBER_Q.
REQ-005 SHALL use d=KYBER_DU for words 0-63 and pack coefficient j at ct_WData[10j+9:10j].
REQ-006 SHALL use d=KYBER_DV for words 64-95, pack coefficient j at ct_WData[4j+3:4j], and drive ct_WData[79:32]=0.
REQ-007 SHALL implement the FSM IDLE -> RD_BP -> RD_V -> DRAIN -> DONE -> IDLE:
- IDLE -> RD_BP when enable=1.
- RD_BP issues addresses 0-63, then goes to RD_V.
- RD_V issues addresses 64-95, then goes to DRAIN.
- DRAIN stays until the last write is issued.
- DONE lasts 1 cycle.
REQ-008 SHALL number cycles n from the edge that samples enable=1 in IDLE (n=0), and follow this timing:
- Add_EncBp_DecMp_RAd = n-1 during cycles 1..96.
- Read data is valid during cycles 2..97.
- ct_outready=1 with ct_WAd=n-3 during cycles 3..98.
- Function_done=1 during cycle 99 only.
REQ-009 SHALL sustain one word per cycle with no bubbles, for a total of 96 writes per run.
REQ-010 SHALL ignore enable outside IDLE, and SHALL start a new run if enable is high in IDLE after DONE.
REQ-011 SHALL hold ct_outready=0 and ct_WData at its last value outside write cycles, and SHALL hold Add_EncBp_DecMp_RAd=0 in IDLE.
REQ-012 SHALL write each ct_WAd exactly once per run, in ascending order with no wrap past 95.

Reset
REQ-013 SHALL, when rst=1 at a clock edge, set: state=IDLE, Add_EncBp_DecMp_RAd=0, ct_outready=0, ct_WAd=0, ct_WData=0, Function_done=0.
REQ-014 SHALL, on reset mid-run, abandon in-flight pipeline data with no further writes and no Function_done pulse; it SHALL NOT resume.
REQ-015 SHALL give rst priority over enable when both are asserted.

Structure
REQ-016 SHALL place KYBER_Q, KYBER_DU, KYBER_DV, the BRAM word widths, and the region base addresses (0, 32, 64, 96) in the shared Kyber parameter package.
REQ-017 SHALL instantiate sub-module State_Compress__Comp (parameter d, 12-bit in, d-bit out, combinational), 8 instances per d or muxed per region; the divide SHALL be realised as a constant multiply-shift proven exact over 0..4095.

Verification
REQ-018 SHALL check that an all-zero Add BRAM with enable pulsed gives 96 writes with ct_WData=0, ct_WAd 0..95 in cycles 3..98, and Function_done in cycle 99.
REQ-019 SHALL check bp boundary values: word 0 coefficients {0,1,1665,3328,832,2496,1664,3000} -> 10-bit values {0,0,512,0,256,768,512,923}.
REQ-020 SHALL check v boundary values: word 64 coefficients {0,832,1664,3328,1,2496,208,3120} -> 4-bit values {0,4,8,0,0,12,1,15} with ct_WData[79:32]=0.
REQ-021 SHALL check reset mid-run: rst=1 at cycle 40 gives no ct_outready from cycle 41 on, no Function_done, and all outputs at reset values.
REQ-022 SHALL check enable handling: enable held high for 200 cycles gives Function_done at cycle 99, IDLE at cycle 100, and a second run with ct_WAd=0 at cycle 104.
REQ-023 SHALL check random canonical coefficients against a reference model of REQ-004, bit-exact over 10 runs.
